// File: rtl/pipeline_hazard_controller.sv
// Pipeline hazard controller: resolves data-memory waits, MEM-stage redirects and
// load-use hazards into per-stage enable/flush controls, with saturating event counters.
module pipeline_hazard_controller (
  input  logic        clock,
  input  logic        reset,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_usesRs,
  input  logic        id_usesRt,
  input  logic        ex_isLoad,
  input  logic [4:0]  ex_registerWriteAddress,
  input  logic        mem_isJump,
  input  logic        mem_isJumpRegister,
  input  logic        mem_isBranch,
  input  logic        mem_isBneElseBeq,
  input  logic        mem_isAluOutputZero,
  input  logic        mem_isMemoryAccess,
  input  logic        dmem_ready,
  output logic        dmem_request,
  output logic        pc_enable,
  output logic        pc_redirect,
  output logic        ifid_enable,
  output logic        ifid_flush,
  output logic        idex_enable,
  output logic        idex_flush,
  output logic        exmem_enable,
  output logic        exmem_flush,
  output logic [15:0] stall_count,
  output logic [15:0] redirect_count
);

  localparam int unsigned CNT_W = 16;
  localparam int unsigned REG_W = 5;

  localparam logic [0:0] ST_RUN      = 1'b0;
  localparam logic [0:0] ST_MEM_WAIT = 1'b1;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [0:0]       r_state;
  logic [0:0]       w_state_next;
  logic [CNT_W-1:0] r_stall_count;
  logic [CNT_W-1:0] r_redirect_count;

  logic w_taken;
  logic w_redirect;
  logic w_load_use;
  logic w_dmem_request;
  logic w_mem_stall;
  logic w_stall_event;
  logic w_redirect_event;

  // Hazard detection terms
  always_comb begin
    w_taken    = mem_isBranch &
                 (mem_isBneElseBeq ? ~mem_isAluOutputZero : mem_isAluOutputZero);
    w_redirect = mem_isJump | mem_isJumpRegister | w_taken;
    w_load_use = ex_isLoad &
                 (ex_registerWriteAddress != REG_W'(0)) &
                 ((id_usesRs & (id_rs == ex_registerWriteAddress)) |
                  (id_usesRt & (id_rt == ex_registerWriteAddress)));
    w_dmem_request = (r_state == ST_MEM_WAIT) | mem_isMemoryAccess;
    w_mem_stall    = w_dmem_request & ~dmem_ready;
  end

  // Next state and prioritised pipeline controls; reset forces every control low
  always_comb begin
    w_state_next     = ST_RUN;
    w_stall_event    = 1'b0;
    w_redirect_event = 1'b0;
    dmem_request     = 1'b0;
    pc_enable        = 1'b0;
    pc_redirect      = 1'b0;
    ifid_enable      = 1'b0;
    ifid_flush       = 1'b0;
    idex_enable      = 1'b0;
    idex_flush       = 1'b0;
    exmem_enable     = 1'b0;
    exmem_flush      = 1'b0;

    if (!reset) begin
      dmem_request = w_dmem_request;
      if (w_mem_stall) begin
        w_state_next  = ST_MEM_WAIT;
        w_stall_event = 1'b1;
      end else if (w_redirect) begin
        w_redirect_event = 1'b1;
        pc_enable        = 1'b1;
        pc_redirect      = 1'b1;
        ifid_enable      = 1'b1;
        ifid_flush       = 1'b1;
        idex_enable      = 1'b1;
        idex_flush       = 1'b1;
        exmem_enable     = 1'b1;
        exmem_flush      = 1'b1;
      end else if (w_load_use) begin
        w_stall_event = 1'b1;
        idex_enable   = 1'b1;
        idex_flush    = 1'b1;
        exmem_enable  = 1'b1;
      end else begin
        pc_enable    = 1'b1;
        ifid_enable  = 1'b1;
        idex_enable  = 1'b1;
        exmem_enable = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Saturating event counters
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_stall_count    <= '0;
      r_redirect_count <= '0;
    end else begin
      if (w_stall_event && (r_stall_count != CNT_MAX)) begin
        r_stall_count <= r_stall_count + CNT_W'(1);
      end
      if (w_redirect_event && (r_redirect_count != CNT_MAX)) begin
        r_redirect_count <= r_redirect_count + CNT_W'(1);
      end
    end
  end

  assign stall_count    = r_stall_count;
  assign redirect_count = r_redirect_count;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed self-checking bench for pipeline_hazard_controller.
module tb_pipeline_hazard_controller;

  logic        clock = 1'b0;
  logic        reset;
  logic [4:0]  id_rs, id_rt;
  logic        id_usesRs, id_usesRt;
  logic        ex_isLoad;
  logic [4:0]  ex_registerWriteAddress;
  logic        mem_isJump, mem_isJumpRegister, mem_isBranch;
  logic        mem_isBneElseBeq, mem_isAluOutputZero;
  logic        mem_isMemoryAccess, dmem_ready;
  logic        dmem_request;
  logic        pc_enable, pc_redirect, ifid_enable, ifid_flush;
  logic        idex_enable, idex_flush, exmem_enable, exmem_flush;
  logic [15:0] stall_count, redirect_count;

  int total = 0;
  int bad   = 0;

  // Control vector order: pc_en, pc_redirect, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush
  localparam logic [7:0] C_ZERO = 8'h00;
  localparam logic [7:0] C_IDLE = 8'hAA;
  localparam logic [7:0] C_LU   = 8'h0E;
  localparam logic [7:0] C_REDR = 8'hFF;

  logic [7:0] ctrl;
  assign ctrl = {pc_enable, pc_redirect, ifid_enable, ifid_flush,
                 idex_enable, idex_flush, exmem_enable, exmem_flush};

  pipeline_hazard_controller dut (
    .clock(clock), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt), .id_usesRs(id_usesRs), .id_usesRt(id_usesRt),
    .ex_isLoad(ex_isLoad), .ex_registerWriteAddress(ex_registerWriteAddress),
    .mem_isJump(mem_isJump), .mem_isJumpRegister(mem_isJumpRegister),
    .mem_isBranch(mem_isBranch), .mem_isBneElseBeq(mem_isBneElseBeq),
    .mem_isAluOutputZero(mem_isAluOutputZero),
    .mem_isMemoryAccess(mem_isMemoryAccess), .dmem_ready(dmem_ready),
    .dmem_request(dmem_request),
    .pc_enable(pc_enable), .pc_redirect(pc_redirect),
    .ifid_enable(ifid_enable), .ifid_flush(ifid_flush),
    .idex_enable(idex_enable), .idex_flush(idex_flush),
    .exmem_enable(exmem_enable), .exmem_flush(exmem_flush),
    .stall_count(stall_count), .redirect_count(redirect_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    id_rs = 5'd0; id_rt = 5'd0; id_usesRs = 1'b0; id_usesRt = 1'b0;
    ex_isLoad = 1'b0; ex_registerWriteAddress = 5'd0;
    mem_isJump = 1'b0; mem_isJumpRegister = 1'b0; mem_isBranch = 1'b0;
    mem_isBneElseBeq = 1'b0; mem_isAluOutputZero = 1'b0;
    mem_isMemoryAccess = 1'b0; dmem_ready = 1'b1;
  endtask

  task automatic set_load_use(input logic [4:0] rd, input logic [4:0] rs, input logic urs,
                              input logic [4:0] rt, input logic urt);
    ex_isLoad = 1'b1; ex_registerWriteAddress = rd;
    id_rs = rs; id_usesRs = urs; id_rt = rt; id_usesRt = urt;
  endtask

  task automatic edge_settle();
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [15:0] s0;
    idle_inputs();
    reset = 1'b1;
    mem_isMemoryAccess = 1'b1;
    dmem_ready = 1'b0;
    #2;
    chk("rst_ctrl", 32'(ctrl), 32'(C_ZERO));
    chk("rst_req", 32'(dmem_request), 32'd0);
    chk("rst_stall", 32'(stall_count), 32'd0);
    chk("rst_redir", 32'(redirect_count), 32'd0);

    // Release reset, idle operation
    @(negedge clock); idle_inputs(); reset = 1'b0; #1;
    chk("idle_ctrl", 32'(ctrl), 32'(C_IDLE));
    chk("idle_req", 32'(dmem_request), 32'd0);
    edge_settle();
    chk("idle_stall", 32'(stall_count), 32'd0);

    // Load-use on rs
    @(negedge clock); set_load_use(5'd8, 5'd8, 1'b1, 5'd0, 1'b0); #1;
    chk("lu_rs_ctrl", 32'(ctrl), 32'(C_LU));
    edge_settle();
    chk("lu_rs_stall", 32'(stall_count), 32'd1);
    @(negedge clock); idle_inputs(); #1;
    chk("lu_after_ctrl", 32'(ctrl), 32'(C_IDLE));

    // Register-zero guard
    @(negedge clock); set_load_use(5'd0, 5'd0, 1'b1, 5'd0, 1'b1); #1;
    chk("r0_ctrl", 32'(ctrl), 32'(C_IDLE));
    edge_settle();
    chk("r0_stall", 32'(stall_count), 32'd1);

    // Load-use via rt; then rs match but rs unused
    @(negedge clock); idle_inputs(); set_load_use(5'd5, 5'd1, 1'b1, 5'd5, 1'b1); #1;
    chk("lu_rt_ctrl", 32'(ctrl), 32'(C_LU));
    edge_settle();
    chk("lu_rt_stall", 32'(stall_count), 32'd2);
    @(negedge clock); set_load_use(5'd9, 5'd9, 1'b0, 5'd3, 1'b1); #1;
    chk("lu_unused_ctrl", 32'(ctrl), 32'(C_IDLE));
    edge_settle();
    chk("lu_unused_stall", 32'(stall_count), 32'd2);

    // bne taken
    @(negedge clock); idle_inputs();
    mem_isBranch = 1'b1; mem_isBneElseBeq = 1'b1; mem_isAluOutputZero = 1'b0; #1;
    chk("bne_t_ctrl", 32'(ctrl), 32'(C_REDR));
    edge_settle();
    chk("bne_t_cnt", 32'(redirect_count), 32'd1);

    // beq not taken, then beq taken, bne not taken
    @(negedge clock); mem_isBneElseBeq = 1'b0; #1;
    chk("beq_nt_ctrl", 32'(ctrl), 32'(C_IDLE));
    edge_settle();
    chk("beq_nt_cnt", 32'(redirect_count), 32'd1);
    @(negedge clock); mem_isAluOutputZero = 1'b1; #1;
    chk("beq_t_ctrl", 32'(ctrl), 32'(C_REDR));
    @(negedge clock); mem_isBneElseBeq = 1'b1; #1;
    chk("bne_nt_ctrl", 32'(ctrl), 32'(C_IDLE));
    chk("beq_t_cnt", 32'(redirect_count), 32'd2);

    // j and jr
    @(negedge clock); idle_inputs(); mem_isJump = 1'b1; #1;
    chk("j_ctrl", 32'(ctrl), 32'(C_REDR));
    @(negedge clock); idle_inputs(); mem_isJumpRegister = 1'b1; #1;
    chk("jr_ctrl", 32'(ctrl), 32'(C_REDR));
    edge_settle();
    chk("jr_cnt", 32'(redirect_count), 32'd4);

    // Load-use together with redirect: redirect wins, no stall counted
    @(negedge clock); idle_inputs(); set_load_use(5'd8, 5'd8, 1'b1, 5'd0, 1'b0); mem_isJump = 1'b1; #1;
    chk("sim_ctrl", 32'(ctrl), 32'(C_REDR));
    edge_settle();
    chk("sim_stall", 32'(stall_count), 32'd2);
    chk("sim_redir", 32'(redirect_count), 32'd5);

    // Memory access completing immediately
    @(negedge clock); idle_inputs(); mem_isMemoryAccess = 1'b1; dmem_ready = 1'b1; #1;
    chk("acc_rdy_ctrl", 32'(ctrl), 32'(C_IDLE));
    chk("acc_rdy_req", 32'(dmem_request), 32'd1);

    // Memory wait: ready low 3 cycles then high
    s0 = stall_count;
    @(negedge clock); idle_inputs(); mem_isMemoryAccess = 1'b1; dmem_ready = 1'b0;
    set_load_use(5'd8, 5'd8, 1'b1, 5'd0, 1'b0); #1;
    chk("mw1_ctrl", 32'(ctrl), 32'(C_ZERO));
    chk("mw1_req", 32'(dmem_request), 32'd1);
    @(negedge clock); idle_inputs(); dmem_ready = 1'b0; #1;
    chk("mw2_ctrl", 32'(ctrl), 32'(C_ZERO));
    chk("mw2_req", 32'(dmem_request), 32'd1);
    @(negedge clock); #1;
    chk("mw3_ctrl", 32'(ctrl), 32'(C_ZERO));
    chk("mw3_req", 32'(dmem_request), 32'd1);
    @(negedge clock); dmem_ready = 1'b1; #1;
    chk("mw4_ctrl", 32'(ctrl), 32'(C_IDLE));
    chk("mw4_req", 32'(dmem_request), 32'd1);
    edge_settle();
    chk("mw_stall", 32'(stall_count - s0), 32'd3);
    @(negedge clock); #1;
    chk("mw_back_req", 32'(dmem_request), 32'd0);

    // Memory stall outranks redirect; redirect taken when ready arrives
    @(negedge clock); idle_inputs(); mem_isMemoryAccess = 1'b1; dmem_ready = 1'b0; mem_isJump = 1'b1; #1;
    chk("ms_j_ctrl", 32'(ctrl), 32'(C_ZERO));
    edge_settle();
    chk("ms_j_cnt", 32'(redirect_count), 32'd5);
    @(negedge clock); dmem_ready = 1'b1; #1;
    chk("ms_j_rdy_ctrl", 32'(ctrl), 32'(C_REDR));
    edge_settle();
    chk("ms_j_rdy_cnt", 32'(redirect_count), 32'd6);

    // Reset during MEM_WAIT
    @(negedge clock); idle_inputs(); mem_isMemoryAccess = 1'b1; dmem_ready = 1'b0;
    edge_settle();
    @(negedge clock); mem_isMemoryAccess = 1'b0; reset = 1'b1; #1;
    chk("rmw_req", 32'(dmem_request), 32'd0);
    chk("rmw_ctrl", 32'(ctrl), 32'(C_ZERO));
    chk("rmw_stall", 32'(stall_count), 32'd0);
    chk("rmw_redir", 32'(redirect_count), 32'd0);
    @(negedge clock); reset = 1'b0; dmem_ready = 1'b0; #1;
    chk("rmw_run_req", 32'(dmem_request), 32'd0);
    chk("rmw_run_ctrl", 32'(ctrl), 32'(C_IDLE));

    // Stall counter saturation
    @(negedge clock); idle_inputs(); set_load_use(5'd8, 5'd8, 1'b1, 5'd0, 1'b0);
    repeat (65534) @(posedge clock);
    #1;
    chk("sat_fffe", 32'(stall_count), 32'hFFFE);
    edge_settle();
    chk("sat_ffff", 32'(stall_count), 32'hFFFF);
    edge_settle();
    chk("sat_hold", 32'(stall_count), 32'hFFFF);
    chk("sat_ctrl", 32'(ctrl), 32'(C_LU));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_controller.md
PIPELINE_HAZARD_CONTROLLER -- requirements
Module: pipeline_hazard_controller

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, named as follows:
  clock  in  1  rising-edge clock shared with all pipeline registers
  reset  in  1  asynchronous, active-high reset
REQ-002 The block SHALL have these ID-stage hazard inputs:
  id_rs  in  5  source register rs of the instruction in ID
  id_rt  in  5  source register rt of the instruction in ID
  id_usesRs  in  1  ID instruction reads rs
  id_usesRt  in  1  ID instruction reads rt
REQ-003 The block SHALL have these EX-stage hazard inputs:
  ex_isLoad  in  1  EX instruction is a load (memory data to register)
  ex_registerWriteAddress  in  5  EX destination register
REQ-004 The block SHALL have these MEM-stage redirect inputs:
  mem_isJump  in  1  j/jal in MEM
  mem_isJumpRegister  in  1  jr in MEM
  mem_isBranch  in  1  beq/bne in MEM
  mem_isBneElseBeq  in  1  1=bne, 0=beq
  mem_isAluOutputZero  in  1  ALU zero flag of the MEM instruction
REQ-005 The block SHALL have these data-memory handshake signals:
  mem_isMemoryAccess  in  1  MEM instruction is a load or store
  dmem_ready  in  1  data memory completes the access this cycle
  dmem_request  out  1  access request to data memory
REQ-006 The block SHALL drive these pipeline-control outputs:
  pc_enable  out  1  PC register update enable
  pc_redirect  out  1  PC mux selects the MEM-stage jump/branch target
  ifid_enable  out  1  IF/ID pipeline register update enable
  ifid_flush  out  1  IF/ID clear to NOP
  idex_enable  out  1  ID/EX pipeline register update enable
  idex_flush  out  1  ID/EX clear to bubble
  exmem_enable  out  1  EX/MEM pipeline register update enable
  exmem_flush  out  1  EX/MEM clear to bubble
REQ-007 The block SHALL drive these 16-bit saturating performance counters:
  stall_count  out  16  stall cycles
  redirect_count  out  16  taken redirects

Function
REQ-008 The FSM SHALL have two states, RUN and MEM_WAIT; all outputs SHALL be combinational from the state and the inputs, and the counters SHALL be registered.
REQ-009 taken SHALL equal mem_isBranch & (mem_isBneElseBeq ? ~mem_isAluOutputZero : mem_isAluOutputZero).
REQ-010 redirect SHALL equal mem_isJump | mem_isJumpRegister | taken.
REQ-011 loadUse SHALL equal ex_isLoad & (ex_registerWriteAddress != 0) & ((id_usesRs & id_rs == ex_registerWriteAddress) | (id_usesRt & id_rt == ex_registerWriteAddress)).
REQ-012 dmem_request SHALL equal mem_isMemoryAccess in RUN, and SHALL be 1 in MEM_WAIT.
REQ-013 The memory-wait condition memStall SHALL equal dmem_request & ~dmem_ready.
REQ-014 Event priority SHALL be: memStall, then redirect, then loadUse, then normal operation.
REQ-015 On memStall, every enable and flush output SHALL be 0, pc_redirect SHALL be 0, the whole pipeline SHALL freeze, and the next state SHALL be MEM_WAIT.
REQ-016 MEM_WAIT SHALL persist while dmem_ready=0; in the cycle dmem_ready=1 the block SHALL evaluate the rules as in RUN and the next state SHALL be RUN.
REQ-017 On redirect without memStall:
  - pc_redirect=1 and pc_enable=1;
  - ifid_flush=1, idex_flush=1 and exmem_flush=1;
  - all enables = 1;
  - a simultaneous loadUse SHALL be ignored, because the ID instruction is squashed.
REQ-018 On loadUse without memStall or redirect:
  - pc_enable=0 and ifid_enable=0;
  - idex_enable=1 with idex_flush=1, inserting one bubble;
  - exmem_enable=1 and exmem_flush=0.
REQ-019 With no event, all enables SHALL be 1, all flushes SHALL be 0, and pc_redirect SHALL be 0.
REQ-020 stall_count SHALL increment by 1 on each cycle with memStall or an effective loadUse, and SHALL saturate at 0xFFFF.
REQ-021 redirect_count SHALL increment by 1 on each effective redirect cycle, and SHALL saturate at 0xFFFF.
REQ-022 A flush asserted together with its enable SHALL take precedence in the downstream register, which SHALL load a bubble.

Reset
REQ-023 While reset=1, the state SHALL be RUN and both counters SHALL be 0, asynchronously.
REQ-024 While reset=1, every enable, flush, pc_redirect and dmem_request output SHALL be 0.
REQ-025 After reset deasserts, the block SHALL obey REQ-008 to REQ-022 from the first rising edge.
REQ-026 Reset asserted during MEM_WAIT SHALL abandon the pending access by dropping dmem_request immediately.

Verification
REQ-027 Load-use: ex_isLoad=1, ex_registerWriteAddress=8, id_rs=8, id_usesRs=1 -> for one cycle pc_enable=0, ifid_enable=0, idex_flush=1; stall_count goes from 0 to 1.
REQ-028 Register-zero guard: the same stimulus with register 0 -> no stall, and all enables stay 1.
REQ-029 Branch, bne taken: mem_isBranch=1, mem_isBneElseBeq=1, mem_isAluOutputZero=0 -> pc_redirect=1, all three flushes=1, redirect_count=1.
REQ-030 Branch, beq not taken: the same stimulus with mem_isBneElseBeq=0 -> no redirect.
REQ-031 Memory wait: mem_isMemoryAccess=1, dmem_ready low for 3 cycles then high -> all enables 0 for 3 cycles, dmem_request=1 for 4 cycles, enables 1 on the 4th cycle, stall_count=3.
REQ-032 Simultaneous events: loadUse together with redirect -> redirect behaviour only, and stall_count is unchanged.
REQ-033 Reset mid-wait: reset pulse during MEM_WAIT -> outputs 0 immediately, state RUN, counters 0.
REQ-034 Saturation: counter preset via 65535 stall cycles, then one more stall -> stall_count stays at 0xFFFF.
